mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FETCH_BUF, default 1: 1 enables the one-entry fetch buffer; 0 fetches every instruction.
REQ-002 i_clk  in  1  clock; all state updates on rising edge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_addr_i  in  32  CPU instruction fetch address.
REQ-005 i_addr_d  in  32  CPU data address (memory-stage result).
REQ-006 i_rd_d  in  1  data read request, ungated by clock enable.
REQ-007 i_we_d  in  4  data byte write enables, ungated by clock enable.
REQ-008 i_data_d  in  32  data write value, already lane-shifted.
REQ-009 o_valid_i / o_valid_d  out  1 each  instruction / data side complete.
REQ-010 o_data_i / o_data_d  out  32 each  fetched instruction / last read data word.
REQ-011 o_mem_req  out  1  memory request.
REQ-012 o_mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
REQ-013 o_mem_we / o_mem_wdata  out  4 / 32  byte enables / write data.
REQ-014 i_mem_ack / i_mem_rdata  in  1 / 32  transfer complete / read word, valid in ack cycle.

Function
REQ-015 States IDLE, FETCH, DATA, DONE; encoding 2 bits.
REQ-016 IDLE lasts exactly one cycle: latches i_addr_i, i_addr_d, i_rd_d, i_we_d, i_data_d into request registers.
REQ-017 IDLE next: FETCH on buffer miss; else DATA if i_rd_d or |i_we_d; else DONE.
REQ-018 Buffer hit = FETCH_BUF && buf_valid && buf_addr[31:2]==i_addr_i[31:2].
REQ-019 FETCH: o_mem_req=1, o_mem_we=0, address from latched fetch address; on ack load o_data_i, buf_addr, buf_valid=1; go to DATA if data op latched, else DONE.
REQ-020 DATA: o_mem_req=1, o_mem_addr from latched data address, o_mem_we=latched i_we_d, o_mem_wdata=latched i_data_d; on ack, a read loads o_data_d; go DONE.
REQ-021 A transfer completes on the edge where o_mem_req && i_mem_ack; req, addr, we, wdata held stable until then.
REQ-022 Write completing in DATA whose word address equals buf_addr SHALL clear buf_valid in the same edge.
REQ-023 An access with both i_rd_d=1 and |i_we_d=1 is treated as a write.
REQ-024 DONE: o_valid_i=o_valid_d=1 for exactly one cycle, then IDLE; at all other times both are 0.
REQ-025 When o_mem_req=0, o_mem_addr, o_mem_we, o_mem_wdata SHALL be 0.
REQ-026 i_mem_ack while o_mem_req=0 is ignored.
REQ-027 o_data_d unchanged by writes and by cycles with no data op.
REQ-028 Cycles per instruction with zero-wait memory: 4 (miss+data op), 3 (miss only or hit+data op), 2 (hit, no data op).
REQ-029 No timeout; FSM waits indefinitely for ack.

Reset
REQ-030 i_rst SHALL force IDLE, buf_valid=0, and o_data_i, o_data_d, request registers to 0, overriding any pending ack.
REQ-031 Reset mid-transfer abandons it: o_mem_req=0 the cycle after reset asserts; memory must tolerate a dropped request.
REQ-032 After reset release the first cycle is IDLE; all outputs 0 until then.

Structure
REQ-033 State encoding and the 4-cycle/2-cycle latency constants belong in the shared config include.
REQ-034 Single module; fetch buffer tag/data/valid kept inline, no sub-module.

Verification
REQ-035 Reset, i_addr_i=0x0, no data op, zero-wait memory returning 0x00000013 -> FETCH req addr 0x0, DONE 2 cycles after IDLE, o_data_i=0x00000013.
REQ-036 i_addr_i=0x100 repeated twice (stall), FETCH_BUF=1 -> second pass no o_mem_req, DONE one cycle after IDLE, o_data_i unchanged; FETCH_BUF=0 -> refetch.
REQ-037 i_addr_d=0x203, i_rd_d=1, ack after 3 wait cycles -> o_mem_addr=0x200 held 4 cycles, o_data_d = i_mem_rdata on ack.
REQ-038 Fetch 0x100 cached, then write i_addr_d=0x102, i_we_d=4'b1100, i_data_d=0xABCD0000 -> o_mem_we=4'b1100, buf_valid cleared, next fetch of 0x100 issues a memory request.
REQ-039 i_rst asserted during DATA with ack pending -> o_mem_req=0 next cycle, no o_valid pulse, buffer invalid, restart from IDLE.
REQ-040 i_rd_d=1 with i_we_d=4'b1111 -> single write transfer, o_data_d unchanged.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared configuration for the instruction/data memory arbiter:
//   - FSM state encoding (2 bits)
//   - best/worst case cycles-per-instruction with zero-wait memory
//   - word-address helper used to build the memory address bus
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DATA  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Cycles per instruction with zero-wait memory:
   // miss + data op takes IDLE/FETCH/DATA/DONE, hit without data op IDLE/DONE.
   localparam int unsigned CPI_MAX = 4;
   localparam int unsigned CPI_MIN = 2;

   function automatic logic [31:0] word_addr(input logic [29:0] tag);
      return {tag, 2'b00};
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Serialises a CPU instruction fetch and an optional data access onto one
// memory port. Each instruction runs IDLE -> [FETCH] -> [DATA] -> DONE. An
// optional one-entry fetch buffer skips FETCH when the same instruction word
// is requested again (e.g. a stalled pipeline re-presenting its address).
//
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_addr_i                  instruction fetch address
//   i_addr_d, i_rd_d, i_we_d  data address, read request, byte write enables
//   i_data_d                  data write value (already lane-shifted)
//   o_valid_i, o_valid_d      one-cycle completion pulse (DONE state)
//   o_data_i, o_data_d        fetched instruction / last read data word
//   o_mem_req/addr/we/wdata   memory request bus (zero while idle)
//   i_mem_ack, i_mem_rdata    memory completion and read data
// ---------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int FETCH_BUF = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_addr_i,
   input  logic [31:0] i_addr_d,
   input  logic        i_rd_d,
   input  logic [3:0]  i_we_d,
   input  logic [31:0] i_data_d,
   output logic        o_valid_i,
   output logic        o_valid_d,
   output logic [31:0] o_data_i,
   output logic [31:0] o_data_d,
   output logic        o_mem_req,
   output logic [31:0] o_mem_addr,
   output logic [3:0]  o_mem_we,
   output logic [31:0] o_mem_wdata,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_rdata
);

   state_e      state_q, state_d;

   // Request registers, captured in IDLE. Only word addresses are kept.
   logic [29:0] fetch_tag_q;
   logic [29:0] data_tag_q;
   logic        rd_q;
   logic [3:0]  we_q;
   logic [31:0] wdata_q;

   // Fetch buffer: tag + valid; the data word is o_data_i itself.
   logic        buf_valid_q;
   logic [29:0] buf_tag_q;
   logic [31:0] data_i_q;
   logic [31:0] data_d_q;

   logic        buf_hit;
   logic        data_op_q;
   logic        xfer_done;

   // Byte offsets never reach the memory bus.
   logic        unused_addr_bits;
   assign unused_addr_bits = ^{i_addr_i[1:0], i_addr_d[1:0]};

   assign buf_hit   = (FETCH_BUF != 0) && buf_valid_q && (buf_tag_q == i_addr_i[31:2]);
   assign data_op_q = rd_q || (we_q != 4'b0000);
   // An ack only counts while a request is actually being driven.
   assign xfer_done = o_mem_req && i_mem_ack;

   assign o_data_i  = data_i_q;
   assign o_data_d  = data_d_q;

   always_comb begin
      state_d     = state_q;
      o_mem_req   = 1'b0;
      o_mem_addr  = 32'h0;
      o_mem_we    = 4'b0000;
      o_mem_wdata = 32'h0;
      o_valid_i   = 1'b0;
      o_valid_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Hit test uses the live fetch address, in parallel with latching.
            if (!buf_hit)
               state_d = ST_FETCH;
            else if (i_rd_d || (i_we_d != 4'b0000))
               state_d = ST_DATA;
            else
               state_d = ST_DONE;
         end
         ST_FETCH: begin
            o_mem_req  = 1'b1;
            o_mem_addr = word_addr(fetch_tag_q);
            if (i_mem_ack)
               state_d = data_op_q ? ST_DATA : ST_DONE;
         end
         ST_DATA: begin
            o_mem_req   = 1'b1;
            o_mem_addr  = word_addr(data_tag_q);
            o_mem_we    = we_q;
            o_mem_wdata = wdata_q;
            if (i_mem_ack)
               state_d = ST_DONE;
         end
         ST_DONE: begin
            o_valid_i = 1'b1;
            o_valid_d = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         fetch_tag_q <= '0;
         data_tag_q  <= '0;
         rd_q        <= 1'b0;
         we_q        <= 4'b0000;
         wdata_q     <= 32'h0;
         buf_valid_q <= 1'b0;
         buf_tag_q   <= '0;
         data_i_q    <= 32'h0;
         data_d_q    <= 32'h0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               fetch_tag_q <= i_addr_i[31:2];
               data_tag_q  <= i_addr_d[31:2];
               rd_q        <= i_rd_d;
               we_q        <= i_we_d;
               wdata_q     <= i_data_d;
            end
            ST_FETCH: begin
               if (xfer_done) begin
                  data_i_q    <= i_mem_rdata;
                  buf_tag_q   <= fetch_tag_q;
                  buf_valid_q <= 1'b1;
               end
            end
            ST_DATA: begin
               if (xfer_done) begin
                  // Any write enable makes this a write, even with rd set.
                  if (we_q != 4'b0000) begin
                     // Self-modifying code: drop a buffered word we overwrite.
                     if (data_tag_q == buf_tag_q)
                        buf_valid_q <= 1'b0;
                  end else begin
                     data_d_q <= i_mem_rdata;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst_b = 1'b1;
   logic        rst_n = 1'b1;
   logic        sel = 1'b0;          // 0: buffered DUT, 1: unbuffered DUT
   logic [31:0] addr_i = '0, addr_d = '0, data_d = '0;
   logic        rd_d = 1'b0;
   logic [3:0]  we_d = '0;
   logic [3:0]  wait_cyc = '0;
   logic        spur_ack = 1'b0;

   logic        vi_b, vd_b, req_b, ack_b, vi_n, vd_n, req_n, ack_n;
   logic [31:0] di_b, dd_b, addr_b, wd_b, rdata_b, di_n, dd_n, addr_n, wd_n, rdata_n;
   logic [3:0]  we_b, we_n, cnt_b, cnt_n;

   always #5 clk = ~clk;

   // Memory model: read word is a fixed function of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h0) ? 32'h0000_0013 : {a[15:0], 16'hA5A5};
   endfunction

   assign ack_b   = (req_b && cnt_b == wait_cyc) || spur_ack;
   assign ack_n   = (req_n && cnt_n == wait_cyc) || spur_ack;
   assign rdata_b = mem_word(addr_b);
   assign rdata_n = mem_word(addr_n);
   always @(posedge clk) begin
      cnt_b <= (!req_b || ack_b) ? 4'd0 : cnt_b + 4'd1;
      cnt_n <= (!req_n || ack_n) ? 4'd0 : cnt_n + 4'd1;
   end

   mem_arbiter #(.FETCH_BUF(1)) dut_b (
      .i_clk(clk), .i_rst(rst_b), .i_addr_i(addr_i), .i_addr_d(addr_d),
      .i_rd_d(rd_d), .i_we_d(we_d), .i_data_d(data_d),
      .o_valid_i(vi_b), .o_valid_d(vd_b), .o_data_i(di_b), .o_data_d(dd_b),
      .o_mem_req(req_b), .o_mem_addr(addr_b), .o_mem_we(we_b), .o_mem_wdata(wd_b),
      .i_mem_ack(ack_b), .i_mem_rdata(rdata_b)
   );

   mem_arbiter #(.FETCH_BUF(0)) dut_n (
      .i_clk(clk), .i_rst(rst_n), .i_addr_i(addr_i), .i_addr_d(addr_d),
      .i_rd_d(rd_d), .i_we_d(we_d), .i_data_d(data_d),
      .o_valid_i(vi_n), .o_valid_d(vd_n), .o_data_i(di_n), .o_data_d(dd_n),
      .o_mem_req(req_n), .o_mem_addr(addr_n), .o_mem_we(we_n), .o_mem_wdata(wd_n),
      .i_mem_ack(ack_n), .i_mem_rdata(rdata_n)
   );

   // Observed DUT
   logic        o_req, o_ack, o_vi, o_vd;
   logic [31:0] o_addr, o_wd, o_di, o_dd;
   logic [3:0]  o_we;
   assign o_req  = sel ? req_n  : req_b;
   assign o_ack  = sel ? ack_n  : ack_b;
   assign o_vi   = sel ? vi_n   : vi_b;
   assign o_vd   = sel ? vd_n   : vd_b;
   assign o_addr = sel ? addr_n : addr_b;
   assign o_wd   = sel ? wd_n   : wd_b;
   assign o_we   = sel ? we_n   : we_b;
   assign o_di   = sel ? di_n   : di_b;
   assign o_dd   = sel ? dd_n   : dd_b;

   int passed = 0;
   int total  = 0;
   int n_cyc, n_req, n_xfer, idle_nonzero = 0;
   logic [31:0] req_addr [8];
   logic [31:0] req_wd   [8];
   logic [3:0]  req_we   [8];
   logic [31:0] got_di, got_dd;
   logic        got_vd, post_valid, timed_out;

   // Runs one instruction; call at the falling edge inside an IDLE cycle.
   // Returns at the falling edge of the following IDLE cycle.
   task automatic run_instr(input logic [31:0] ai, input logic [31:0] ad,
                            input logic rd, input logic [3:0] we, input logic [31:0] wd);
      logic done;
      addr_i = ai; addr_d = ad; rd_d = rd; we_d = we; data_d = wd;
      n_cyc = 0; n_req = 0; n_xfer = 0; done = 1'b0; timed_out = 1'b0; got_vd = 1'b0;
      while (!done) begin
         @(negedge clk);
         n_cyc++;
         if (o_req) begin
            if (n_req < 8) begin
               req_addr[n_req] = o_addr; req_we[n_req] = o_we; req_wd[n_req] = o_wd;
            end
            n_req++;
            if (o_ack) n_xfer++;
         end else if (o_addr != 32'h0 || o_we != 4'h0 || o_wd != 32'h0) begin
            idle_nonzero++;
         end
         if (o_vi) begin
            done = 1'b1; got_di = o_di; got_dd = o_dd; got_vd = o_vd;
         end else if (n_cyc >= 40) begin
            done = 1'b1; timed_out = 1'b1;
         end
      end
      total++; if (timed_out) $display("FAIL done_timeout: no o_valid_i after %0d cycles, required within 40", n_cyc); else passed++;
      @(negedge clk);
      post_valid = o_vi | o_vd;
      $display("instr dut=%0d ai=%h ad=%h rd=%0d we=%b cycles=%0d reqs=%0d xfers=%0d di=%h dd=%h",
               sel, ai, ad, rd, we, n_cyc + 1, n_req, n_xfer, got_di, got_dd);
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      total++; if (req_b !== 1'b0) $display("FAIL rst_req: got %b want 0", req_b); else passed++;
      total++; if ({addr_b, we_b, wd_b} !== 68'h0) $display("FAIL rst_bus: got %h/%b/%h want 0", addr_b, we_b, wd_b); else passed++;
      total++; if ({vi_b, vd_b} !== 2'b00) $display("FAIL rst_valid: got %b want 00", {vi_b, vd_b}); else passed++;
      total++; if ({di_b, dd_b} !== 64'h0) $display("FAIL rst_data: got %h/%h want 0", di_b, dd_b); else passed++;
      rst_b = 1'b0;
      $display("reset released dut=0");
   endtask

   task automatic test_fetch_basic;
      run_instr(32'h0, 32'h0, 1'b0, 4'h0, 32'h0);
      total++; if (n_cyc + 1 !== 3) $display("FAIL fetch_cpi: got %0d want 3", n_cyc + 1); else passed++;
      total++; if (n_req !== 1 || req_addr[0] !== 32'h0 || req_we[0] !== 4'h0) $display("FAIL fetch_req: got n=%0d a=%h we=%b want 1/0/0", n_req, req_addr[0], req_we[0]); else passed++;
      total++; if (got_di !== 32'h0000_0013) $display("FAIL fetch_data: got %h want 00000013", got_di); else passed++;
      total++; if (got_vd !== 1'b1 || post_valid !== 1'b0) $display("FAIL valid_pulse: got vd=%b post=%b want 1/0", got_vd, post_valid); else passed++;
   endtask

   task automatic test_buffer_hit;
      run_instr(32'h100, 32'h0, 1'b0, 4'h0, 32'h0);
      total++; if (got_di !== 32'h0100_A5A5) $display("FAIL miss_data: got %h want 0100a5a5", got_di); else passed++;
      spur_ack = 1'b1;   // an ack with no request must be ignored
      run_instr(32'h100, 32'h0, 1'b0, 4'h0, 32'h0);
      spur_ack = 1'b0;
      total++; if (n_req !== 0) $display("FAIL hit_noreq: got %0d reqs want 0", n_req); else passed++;
      total++; if (n_cyc + 1 !== CPI_MIN) $display("FAIL hit_cpi: got %0d want %0d", n_cyc + 1, CPI_MIN); else passed++;
      total++; if (got_di !== 32'h0100_A5A5) $display("FAIL hit_data: got %h want 0100a5a5", got_di); else passed++;
   endtask

   task automatic test_data_wait;
      int bad = 0;
      wait_cyc = 4'd3;
      run_instr(32'h100, 32'h203, 1'b1, 4'h0, 32'h0);
      wait_cyc = 4'd0;
      for (int i = 0; i < 4; i++) if (req_addr[i] !== 32'h200 || req_we[i] !== 4'h0) bad++;
      total++; if (n_req !== 4 || bad !== 0) $display("FAIL rd_hold: got n=%0d bad=%0d want 4/0", n_req, bad); else passed++;
      total++; if (n_cyc !== 5) $display("FAIL rd_cycles: got %0d want 5", n_cyc); else passed++;
      total++; if (got_dd !== 32'h0200_A5A5) $display("FAIL rd_data: got %h want 0200a5a5", got_dd); else passed++;
   endtask

   task automatic test_miss_data;
      run_instr(32'h2C0, 32'h204, 1'b1, 4'h0, 32'h0);
      total++; if (n_cyc + 1 !== CPI_MAX) $display("FAIL miss_rd_cpi: got %0d want %0d", n_cyc + 1, CPI_MAX); else passed++;
      total++; if (req_addr[0] !== 32'h2C0 || req_addr[1] !== 32'h204) $display("FAIL miss_rd_order: got %h,%h want 2c0,204", req_addr[0], req_addr[1]); else passed++;
      total++; if (got_di !== 32'h02C0_A5A5 || got_dd !== 32'h0204_A5A5) $display("FAIL miss_rd_data: got %h/%h want 02c0a5a5/0204a5a5", got_di, got_dd); else passed++;
   endtask

   task automatic test_write_invalidate;
      run_instr(32'h100, 32'h0, 1'b0, 4'h0, 32'h0);
      run_instr(32'h100, 32'h102, 1'b0, 4'b1100, 32'hABCD_0000);
      total++; if (n_req !== 1 || req_addr[0] !== 32'h100) $display("FAIL wr_req: got n=%0d a=%h want 1/100", n_req, req_addr[0]); else passed++;
      total++; if (req_we[0] !== 4'b1100 || req_wd[0] !== 32'hABCD_0000) $display("FAIL wr_bus: got %b/%h want 1100/abcd0000", req_we[0], req_wd[0]); else passed++;
      total++; if (got_dd !== 32'h0204_A5A5) $display("FAIL wr_keep_dd: got %h want 0204a5a5", got_dd); else passed++;
      run_instr(32'h100, 32'h0, 1'b0, 4'h0, 32'h0);
      total++; if (n_req !== 1 || n_cyc !== 2) $display("FAIL wr_inval: got n=%0d cyc=%0d want 1/2", n_req, n_cyc); else passed++;
   endtask

   task automatic test_rd_we_both;
      run_instr(32'h100, 32'h400, 1'b1, 4'b1111, 32'h1122_3344);
      total++; if (n_req !== 1 || n_xfer !== 1) $display("FAIL both_single: got n=%0d x=%0d want 1/1", n_req, n_xfer); else passed++;
      total++; if (req_we[0] !== 4'b1111 || req_wd[0] !== 32'h1122_3344) $display("FAIL both_write: got %b/%h want 1111/11223344", req_we[0], req_wd[0]); else passed++;
      total++; if (got_dd !== 32'h0204_A5A5) $display("FAIL both_keep_dd: got %h want 0204a5a5", got_dd); else passed++;
      total++; if (idle_nonzero !== 0) $display("FAIL idle_bus_zero: got %0d nonzero cycles want 0", idle_nonzero); else passed++;
   endtask

   task automatic test_reset_mid;
      wait_cyc = 4'd5;
      addr_i = 32'h100; addr_d = 32'h300; rd_d = 1'b1; we_d = 4'h0; data_d = 32'h0;
      @(negedge clk);
      total++; if (req_b !== 1'b1 || addr_b !== 32'h300) $display("FAIL mid_in_data: got req=%b a=%h want 1/300", req_b, addr_b); else passed++;
      rst_b = 1'b1;
      @(negedge clk);
      total++; if (req_b !== 1'b0 || {vi_b, vd_b} !== 2'b00) $display("FAIL mid_drop: got req=%b v=%b want 0/00", req_b, {vi_b, vd_b}); else passed++;
      total++; if ({di_b, dd_b} !== 64'h0) $display("FAIL mid_clear: got %h/%h want 0", di_b, dd_b); else passed++;
      rst_b = 1'b0; wait_cyc = 4'd0;
      $display("reset pulse mid-transfer dut=0");
      run_instr(32'h100, 32'h0, 1'b0, 4'h0, 32'h0);
      total++; if (n_req !== 1 || got_di !== 32'h0100_A5A5) $display("FAIL mid_refetch: got n=%0d di=%h want 1/0100a5a5", n_req, got_di); else passed++;
   endtask

   task automatic test_nobuf;
      @(negedge clk);
      rst_b = 1'b1; sel = 1'b1;
      total++; if ({req_n, vi_n, di_n, dd_n} !== 66'h0) $display("FAIL nobuf_rst: got %b/%b/%h/%h want 0", req_n, vi_n, di_n, dd_n); else passed++;
      rst_n = 1'b0;
      $display("reset released dut=1");
      for (int k = 0; k < 2; k++) begin
         run_instr(32'h100, 32'h0, 1'b0, 4'h0, 32'h0);
         total++; if (n_req !== 1 || n_cyc !== 2 || got_di !== 32'h0100_A5A5) $display("FAIL nobuf_refetch%0d: got n=%0d cyc=%0d di=%h want 1/2/0100a5a5", k, n_req, n_cyc, got_di); else passed++;
      end
   endtask

   initial begin
      test_reset;
      test_fetch_basic;
      test_buffer_hit;
      test_data_wait;
      test_miss_data;
      test_write_invalidate;
      test_rd_we_both;
      test_reset_mid;
      test_nobuf;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
